c17_misr_compactor: RTL

Downstream response compactor for the c17 benchmark netlist. It consumes the two primary outputs (N22, N23) once per applied test vector and folds them into a multiple-input signature register (MISR). After a programmed number of vectors it compares the signature against a golden value and reports pass/fail. It sits directly after the c17 combinational core in the PSOracle test harness, behind a valid/ready handshake from the vector-application stage.

---
 rtl/c17_misr_pkg.sv | 28 ++
 rtl/c17_misr_lfsr.sv | 31 +++
 rtl/c17_misr_compactor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/c17_misr_pkg.sv
// Shared types, default constants and the MISR fold step for the c17 response compactor.
package c17_misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEF_POLY = 16'h002D;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // One Galois MISR step on a w-bit signature carried in a 32-bit container.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [1:0]  resp,
                                            input logic [31:0] poly,
                                            input int unsigned w);
    logic [31:0] r;
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = (sig << 1) ^ {30'd0, resp};
    if (((sig >> (w - 1)) & 32'd1) != 32'd0) begin
      r = r ^ poly;
    end
    return r & mask;
  endfunction

endpackage

// File: rtl/c17_misr_lfsr.sv
// Signature register: loads SEED on load/reset, folds a 2-bit response when enabled.
module c17_misr_lfsr
  import c17_misr_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [1:0]       resp_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [SIG_W-1:0] sig_nxt_o
);

  logic [SIG_W-1:0] sig_q;

  assign sig_nxt_o = SIG_W'(misr_next(32'(sig_q), resp_i, 32'(POLY), SIG_W));
  assign sig_o     = sig_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      sig_q <= SEED;
    end else if (en_i) begin
      sig_q <= sig_nxt_o;
    end
  end

endmodule

// File: rtl/c17_misr_compactor.sv
// c17 response compactor: FSM, beat counter and golden compare around the MISR.
// Optional unknown-masking input enabled by defining C17_MISR_XMASK_EN.
module c17_misr_compactor
  import c17_misr_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] golden,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_n22,
  input  logic             in_n23,
`ifdef C17_MISR_XMASK_EN
  input  logic [1:0]       in_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, num_q;
  logic [SIG_W-1:0] golden_q, sig_nxt;
  logic             pass_q;
  logic             start_ok, accept, last_beat;
  logic [1:0]       resp;

`ifdef C17_MISR_XMASK_EN
  assign resp = {in_n23 & ~in_mask[1], in_n22 & ~in_mask[0]};
`else
  assign resp = {in_n23, in_n22};
`endif

  assign start_ok  = start && (state_q != ST_RUN);
  assign accept    = in_valid && (state_q == ST_RUN);
  assign last_beat = accept && ((vec_cnt_q + CNT_W'(1)) == num_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // pass is settled on the same edge that enters DONE, using the folded value
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt_q <= '0;
      num_q     <= '0;
      golden_q  <= '0;
      pass_q    <= 1'b0;
    end else if (start_ok) begin
      vec_cnt_q <= '0;
      num_q     <= num_vec;
      golden_q  <= golden;
      pass_q    <= (num_vec == '0) && (SEED == golden);
    end else if (accept) begin
      vec_cnt_q <= vec_cnt_q + CNT_W'(1);
      if (last_beat) begin
        pass_q <= (sig_nxt == golden_q);
      end
    end
  end

  c17_misr_lfsr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (start_ok),
    .en_i      (accept),
    .resp_i    (resp),
    .sig_o     (signature),
    .sig_nxt_o (sig_nxt)
  );

  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;

endmodule
